fetch_queue: RTL
================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, instruction queue entries (power of two, 2..16).
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port AnyStall  in  1  decode holds the current instruction; no pop.
REQ-006 SHALL have port Jump_ID  in  1  jump redirect request.
REQ-007 SHALL have port JumpTgt_ID  in  26  jump target field.
REQ-008 SHALL have port BranchTaken_EX  in  1  branch redirect request.
REQ-009 SHALL have port RedirectPc_EX  in  32  branch target.
REQ-010 SHALL have port ImemReq_IF  out  1  instruction memory request valid.
REQ-011 SHALL have port ImemAddr_IF  out  32  request word address (byte address, [1:0]=0).
REQ-012 SHALL have port ImemAck  in  1  request accepted this cycle.
REQ-013 SHALL have port ImemValid  in  1  in-order response valid.
REQ-014 SHALL have port ImemData  in  32  response instruction.
REQ-015 SHALL have port FetchData_IF  out  32  instruction to decode; 0 (NOP) when not valid.
REQ-016 SHALL have port FetchValid_IF  out  1  FetchData_IF holds a real instruction.
REQ-017 SHALL have port FetchPc_IF  out  32  address of FetchData_IF.

Function
REQ-018 SHALL hold a PC register, an outstanding-request counter (0..DEPTH), a drop counter, and a DEPTH-entry FIFO of {pc, instr}.
REQ-019 SHALL assert ImemReq_IF in RUN when occupancy + outstanding < DEPTH and no redirect is asserted; ImemAddr_IF = PC.
REQ-020 SHALL, on ImemReq_IF & ImemAck, advance PC by 4 (wraps mod 2^32) and increment outstanding.
REQ-021 SHALL, on ImemValid with drop = 0, push {response pc, ImemData} and decrement outstanding; response pc tracked by a separate fetch-address counter.
REQ-022 SHALL pop the head when FetchValid_IF & !AnyStall; simultaneous push and pop SHALL be legal at any occupancy, including full.
REQ-023 SHALL present the head combinationally: FetchValid_IF = !empty, FetchData_IF/FetchPc_IF = head or 0 when empty.
REQ-024 SHALL treat redirect priority: BranchTaken_EX over Jump_ID; jump target = {PC[31:28], JumpTgt_ID, 2'b00}.
REQ-025 SHALL, on redirect: load PC with target, empty the FIFO (head discarded, no pop), set drop = outstanding (plus 1 if a same-cycle ImemValid is not counted), deassert ImemReq_IF that cycle, enter FLUSH.
REQ-026 SHALL permit ImemReq_IF withdrawal without ack only in the redirect cycle.
REQ-027 SHALL, in FLUSH, discard each ImemValid response, decrementing drop and outstanding, issue no request, and return to RUN the cycle after drop reaches 0 (immediately if drop = 0).
REQ-028 SHALL let a new redirect during FLUSH reload PC and keep dropping remaining stale responses.
REQ-029 SHALL ignore ImemValid when outstanding = 0 (protocol error; no state change).
REQ-030 SHALL have states RESET_WAIT -> RUN (one cycle after reset release), RUN -> FLUSH on redirect, FLUSH -> RUN per REQ-027.
REQ-031 SHALL never let occupancy + outstanding exceed DEPTH.

Reset
REQ-032 SHALL, while reset = 0, set PC = RESET_PC, FIFO empty, outstanding = drop = 0, state RESET_WAIT, ImemReq_IF = 0, FetchValid_IF = 0, FetchData_IF = 0, FetchPc_IF = 0, ImemAddr_IF = RESET_PC.
REQ-033 SHALL, on reset mid-operation, abandon in-flight responses; the memory model is reset with the block.

Structure
REQ-034 SHALL place state encoding (RESET_WAIT, RUN, FLUSH) and NOP constant 32'h0 in the shared core package.
REQ-035 SHALL instantiate one sub-module, fifo_sync (parameter WIDTH=64, DEPTH), for the {pc, instr} queue.

Verification
REQ-036 SHALL cover: reset release, ImemAck=1, 1-cycle response latency -> addresses 0,4,8,C issued back-to-back; FetchPc_IF 0 first valid at cycle 3.
REQ-037 SHALL cover: AnyStall=1 for 10 cycles -> ImemReq_IF drops after 4 credits used; head stays PC 0; no loss on release.
REQ-038 SHALL cover: Jump_ID=1, JumpTgt_ID=26'h40 with PC=0x10 -> queue flushed, next request 0x100, FetchValid_IF=0 until 0x100 returns.
REQ-039 SHALL cover: 2 outstanding, BranchTaken_EX=1 to 0x200 same cycle as Jump_ID -> 2 responses dropped, next fetch 0x200.
REQ-040 SHALL cover: full FIFO, pop and ImemValid same cycle -> occupancy stays 4, ordering preserved.
REQ-041 SHALL cover: reset asserted with 3 outstanding -> all outputs to REQ-032 values immediately; restart at RESET_PC.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// Shared definitions for the instruction fetch queue: FSM state encoding
// and the bubble instruction presented to decode when nothing is valid.
package fetch_queue_pkg;

  typedef enum logic [1:0] {
    RESET_WAIT = 2'd0,
    RUN        = 2'd1,
    FLUSH      = 2'd2
  } state_t;

  localparam logic [31:0] NOP = 32'h0000_0000;

endpackage

// File: rtl/fetch_queue_fifo_sync.sv
// Single-clock FIFO with a combinational head view; push and pop may coincide
// at any occupancy, including full, and flush empties it in one cycle.
module fifo_sync #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // When full, the slot freed by a same-cycle pop is the one being written.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Credit-limited instruction fetch front end: issues in-order memory requests,
// queues responses for decode, and discards stale responses after a redirect.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        AnyStall,
  input  logic        Jump_ID,
  input  logic [25:0] JumpTgt_ID,
  input  logic        BranchTaken_EX,
  input  logic [31:0] RedirectPc_EX,
  output logic        ImemReq_IF,
  output logic [31:0] ImemAddr_IF,
  input  logic        ImemAck,
  input  logic        ImemValid,
  input  logic [31:0] ImemData,
  output logic [31:0] FetchData_IF,
  output logic        FetchValid_IF,
  output logic [31:0] FetchPc_IF
);

  localparam int CW = $clog2(DEPTH) + 1;

  state_t        state;
  logic [31:0]   pc;
  logic [31:0]   resp_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop;
  logic [CW-1:0] drop_left;
  logic [CW-1:0] count;
  logic [31:0]   target;
  logic [63:0]   head;
  logic          empty;
  logic          redirect;
  logic          rsp;
  logic          accept;
  logic          push;
  logic          pop;

  assign redirect  = (state != RESET_WAIT) && (BranchTaken_EX || Jump_ID);
  assign target    = BranchTaken_EX ? RedirectPc_EX : {pc[31:28], JumpTgt_ID, 2'b00};
  // A response with nothing in flight is a protocol error and is ignored.
  assign rsp       = ImemValid && (outstanding != '0);
  assign drop_left = drop - CW'(rsp);

  // Credits cover both queued entries and requests still in flight.
  assign ImemReq_IF  = (state == RUN) && !redirect &&
                       ((CW+1)'(count) + (CW+1)'(outstanding) < (CW+1)'(DEPTH));
  assign ImemAddr_IF = pc;
  assign accept      = ImemReq_IF && ImemAck;
  assign push        = rsp && (state == RUN) && !redirect;
  assign pop         = !empty && !AnyStall && !redirect;

  assign FetchValid_IF = !empty;
  assign FetchData_IF  = empty ? NOP : head[31:0];
  assign FetchPc_IF    = empty ? NOP : head[63:32];

  fifo_sync #(
    .WIDTH (64),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (redirect),
    .push  (push),
    .pop   (pop),
    .din   ({resp_pc, ImemData}),
    .dout  (head),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= RESET_WAIT;
      pc          <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
    end else begin
      outstanding <= outstanding + CW'(accept) - CW'(rsp);
      case (state)
        RESET_WAIT: state <= RUN;
        RUN: begin
          if (redirect) begin
            pc      <= target;
            resp_pc <= target;
            // A response arriving in the redirect cycle is discarded here.
            drop    <= outstanding - CW'(rsp);
            state   <= FLUSH;
          end else begin
            if (accept) pc      <= pc + 32'd4;
            if (push)   resp_pc <= resp_pc + 32'd4;
          end
        end
        FLUSH: begin
          if (redirect) begin
            pc      <= target;
            resp_pc <= target;
          end
          drop  <= drop_left;
          state <= (drop_left == '0) ? RUN : FLUSH;
        end
        default: state <= RESET_WAIT;
      endcase
    end
  end

endmodule
